axi4_lite_slave_mem_responder: RTL and testbench

AXI4_LITE_SLAVE_MEM_RESPONDER -- requirements
Module: axi4_lite_slave_mem_responder

---
 rtl/axi4_lite_slave_mem_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_axi4_lite_slave_mem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_mem_responder
// Brief    : AXI4-Lite slave backed by a small word memory, with configurable
//            per-transaction ready delays on the write and read paths.
// Revision : 1.0
// ============================================================================
module axi4_lite_slave_mem_responder #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       DELAY_WIDTH   = 5,
    parameter int                       MEM_DEPTH     = 16,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
    parameter bit                       SECURE_ONLY   = 1'b0
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [ADDRESS_WIDTH-1:0]  awaddr,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDRESS_WIDTH-1:0]  araddr,
    input  logic [2:0]                arprot,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    input  logic [DELAY_WIDTH-1:0]    cfg_write_delay,
    input  logic [DELAY_WIDTH-1:0]    cfg_read_delay
);

    localparam int         c_strb_w      = DATA_WIDTH / 8;
    localparam int         c_idx_w       = $clog2(MEM_DEPTH);
    localparam int         c_tag_lsb     = c_idx_w + 2;
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // Base is aligned to the window size, so the range test reduces to a tag compare.
    function automatic logic [1:0] f_decode(input logic [ADDRESS_WIDTH-1:0] addr,
                                            input logic                     nonsecure);
        if (addr[ADDRESS_WIDTH-1:c_tag_lsb] != BASE_ADDR[ADDRESS_WIDTH-1:c_tag_lsb])
            return c_resp_decerr;
        else if (addr[1:0] != 2'b00)
            return c_resp_slverr;
        else if (SECURE_ONLY && nonsecure)
            return c_resp_slverr;
        return c_resp_okay;
    endfunction

    logic [DATA_WIDTH-1:0]  r_mem [MEM_DEPTH];

    state_t                 r_wr_state;
    state_t                 w_wr_state_nxt;
    logic [DELAY_WIDTH-1:0] r_wr_cnt;
    logic                   w_wr_load;
    logic                   w_wr_commit;
    logic [1:0]             r_bresp;
    logic [1:0]             w_aw_resp;
    logic [c_idx_w-1:0]     w_aw_idx;

    state_t                 r_rd_state;
    state_t                 w_rd_state_nxt;
    logic [DELAY_WIDTH-1:0] r_rd_cnt;
    logic                   w_rd_load;
    logic                   w_rd_capture;
    logic [1:0]             r_rresp;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic [1:0]             w_ar_resp;
    logic [c_idx_w-1:0]     w_ar_idx;

    logic                   w_unused;

    assign w_aw_resp = f_decode(awaddr, awprot[1]);
    assign w_ar_resp = f_decode(araddr, arprot[1]);
    assign w_aw_idx  = awaddr[2 +: c_idx_w];
    assign w_ar_idx  = araddr[2 +: c_idx_w];
    assign w_unused  = ^{awprot[2], awprot[0], arprot[2], arprot[0]};

    assign bresp = r_bresp;
    assign rresp = r_rresp;
    assign rdata = r_rdata;

    // ------------------------------------------------------------------ write
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_wr_state <= S_IDLE;
        else
            r_wr_state <= w_wr_state_nxt;
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        awready        = 1'b0;
        wready         = 1'b0;
        bvalid         = 1'b0;
        w_wr_load      = 1'b0;
        w_wr_commit    = 1'b0;
        case (r_wr_state)
            S_IDLE: begin
                if (awvalid && wvalid) begin
                    w_wr_load      = 1'b1;
                    w_wr_state_nxt = S_DELAY;
                end
            end
            S_DELAY: begin
                if (r_wr_cnt == '0) begin
                    awready = 1'b1;
                    wready  = 1'b1;
                    if (awvalid && wvalid) begin
                        w_wr_commit    = 1'b1;
                        w_wr_state_nxt = S_RESP;
                    end
                end
            end
            S_RESP: begin
                bvalid = 1'b1;
                if (bready)
                    w_wr_state_nxt = S_IDLE;
            end
            default: w_wr_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_cnt <= '0;
            r_bresp  <= c_resp_okay;
        end else begin
            if (w_wr_load)
                r_wr_cnt <= cfg_write_delay;
            else if (r_wr_state == S_DELAY && r_wr_cnt != '0)
                r_wr_cnt <= r_wr_cnt - 1'b1;
            if (w_wr_commit)
                r_bresp <= w_aw_resp;
        end
    end

    // Nonblocking update keeps a same-edge read capture on the old contents.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_wr_commit && w_aw_resp == c_resp_okay) begin
            for (int b = 0; b < c_strb_w; b++)
                if (wstrb[b])
                    r_mem[w_aw_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // ------------------------------------------------------------------- read
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_rd_state <= S_IDLE;
        else
            r_rd_state <= w_rd_state_nxt;
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        arready        = 1'b0;
        rvalid         = 1'b0;
        w_rd_load      = 1'b0;
        w_rd_capture   = 1'b0;
        case (r_rd_state)
            S_IDLE: begin
                if (arvalid) begin
                    w_rd_load      = 1'b1;
                    w_rd_state_nxt = S_DELAY;
                end
            end
            S_DELAY: begin
                if (r_rd_cnt == '0) begin
                    arready = 1'b1;
                    if (arvalid) begin
                        w_rd_capture   = 1'b1;
                        w_rd_state_nxt = S_RESP;
                    end
                end
            end
            S_RESP: begin
                rvalid = 1'b1;
                if (rready)
                    w_rd_state_nxt = S_IDLE;
            end
            default: w_rd_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_cnt <= '0;
            r_rresp  <= c_resp_okay;
            r_rdata  <= '0;
        end else begin
            if (w_rd_load)
                r_rd_cnt <= cfg_read_delay;
            else if (r_rd_state == S_DELAY && r_rd_cnt != '0)
                r_rd_cnt <= r_rd_cnt - 1'b1;
            if (w_rd_capture) begin
                r_rresp <= w_ar_resp;
                r_rdata <= (w_ar_resp == c_resp_okay) ? r_mem[w_ar_idx] : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_slave_mem_responder
// Brief    : Directed plus randomized bench with a byte-lane memory model.
// Revision : 1.0
// ============================================================================
module tb_axi4_lite_slave_mem_responder;

    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam bit          SECURE = 1'b1;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          arvalid, arready, rvalid, rready;
    logic [4:0]    cfg_write_delay, cfg_read_delay;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_mem [DEPTH];

    axi4_lite_slave_mem_responder #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DELAY_WIDTH(5), .MEM_DEPTH(DEPTH),
        .BASE_ADDR(BASE), .SECURE_ONLY(SECURE)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .cfg_write_delay(cfg_write_delay), .cfg_read_delay(cfg_read_delay)
    );

    always #5 aclk = ~aclk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [2:0] prot);
        longint a;
        a = longint'(addr);
        if (a < longint'(BASE) || a >= longint'(BASE) + DEPTH * 4) return 2'b11;
        if (addr % 4 != 0) return 2'b10;
        if (SECURE && prot[1]) return 2'b10;
        return 2'b00;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [2:0] prot,
                            input logic [31:0] data, input logic [3:0] strb,
                            input int d, input int hold, input bit poke);
        logic [1:0] er;
        int n, idx;
        er = exp_resp(addr, prot);
        cfg_write_delay = d[4:0];
        awaddr = addr; awprot = prot; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        do begin
            @(posedge aclk); #1; n++;
            cfg_write_delay = 5'($urandom);
        end while (!awready && n < 100);
        chk("aw_latency", 64'(n), 64'(d + 1));
        chk("wready_hs", wready, 1'b1);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("awready_drop", awready, 1'b0);
        chk("bvalid", bvalid, 1'b1);
        chk("bresp", bresp, er);
        if (er == 2'b00) begin
            idx = int'((addr - BASE) / 4);
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
        end
        for (int h = 0; h < hold; h++) begin
            if (poke) begin awvalid = 1'b1; wvalid = 1'b1; end
            @(posedge aclk); #1;
            chk("bvalid_hold", bvalid, 1'b1);
            chk("bresp_hold", bresp, er);
            chk("awready_in_resp", awready, 1'b0);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        chk("bvalid_done", bvalid, 1'b0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] prot,
                           input int d, input int hold, output logic [31:0] got);
        logic [1:0]  er;
        logic [31:0] ed;
        int n;
        er = exp_resp(addr, prot);
        cfg_read_delay = d[4:0];
        araddr = addr; arprot = prot; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        do begin
            @(posedge aclk); #1; n++;
            cfg_read_delay = 5'($urandom);
        end while (!arready && n < 100);
        chk("ar_latency", 64'(n), 64'(d + 1));
        // Expected data is taken before the capture edge so same-edge writes do not count.
        ed = (er == 2'b00) ? model_mem[(addr - BASE) / 4] : 32'h0;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        chk("arready_drop", arready, 1'b0);
        chk("rvalid", rvalid, 1'b1);
        chk("rresp", rresp, er);
        chk("rdata", rdata, ed);
        got = rdata;
        for (int h = 0; h < hold; h++) begin
            @(posedge aclk); #1;
            chk("rvalid_hold", rvalid, 1'b1);
            chk("rdata_hold", rdata, ed);
            chk("rresp_hold", rresp, er);
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        chk("rvalid_done", rvalid, 1'b0);
    endtask

    initial begin
        logic [31:0] got, got_w, a;
        bit seen_b;
        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        cfg_write_delay = '0; cfg_read_delay = '0;
        clear_model();

        #12;
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_rdata", rdata, 32'h0);
        @(posedge aclk); #1;
        aresetn = 1'b1;

        // Basic write with delay 3, then immediate read-back.
        do_write(32'h4, 3'b000, 32'hDEADBEEF, 4'hF, 3, 0, 1'b0);
        do_read(32'h4, 3'b000, 0, 0, got);
        chk("deadbeef", got, 32'hDEADBEEF);

        // Partial strobes over an all-ones word.
        do_write(32'h8, 3'b000, 32'hFFFFFFFF, 4'hF, 0, 0, 1'b0);
        do_write(32'h8, 3'b000, 32'h11223344, 4'h5, 1, 0, 1'b0);
        do_read(32'h8, 3'b000, 2, 1, got);
        chk("strobe_merge", got, 32'hFF22FF44);

        // Error responses and empty strobe.
        do_write(32'h40, 3'b000, 32'hCAFEF00D, 4'hF, 0, 0, 1'b0);
        do_read(32'h6, 3'b000, 0, 0, got);
        do_write(32'hC, 3'b010, 32'h12345678, 4'hF, 0, 0, 1'b0);
        do_read(32'h4, 3'b010, 0, 0, got);
        do_write(32'h4, 3'b000, 32'h0BADF00D, 4'h0, 0, 0, 1'b0);
        do_read(32'h4, 3'b000, 0, 0, got);
        chk("nostrobe", got, 32'hDEADBEEF);

        // Backpressure on B while a new write is offered.
        do_write(32'h10, 3'b001, 32'h5A5A0001, 4'hF, 2, 10, 1'b1);

        // Maximum delay on both paths.
        do_write(32'h14, 3'b000, 32'h31313131, 4'hF, 31, 0, 1'b0);
        do_read(32'h14, 3'b000, 31, 0, got);

        for (int k = 0; k < 30; k++) begin
            a = 32'($urandom_range(0, 79));
            if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
            if (k % 2 == 0)
                do_write(a, 3'($urandom_range(0, 7)), $urandom, 4'($urandom),
                         $urandom_range(0, 6), $urandom_range(0, 3), 1'b0);
            else
                do_read(a, 3'($urandom_range(0, 7)), $urandom_range(0, 6),
                        $urandom_range(0, 3), got);
        end

        // Same-edge write commit and read capture on word 2.
        do_write(32'h8, 3'b000, 32'h00000001, 4'hF, 0, 0, 1'b0);
        fork
            do_write(32'h8, 3'b000, 32'hA5A5A5A5, 4'hF, 2, 0, 1'b0);
            do_read(32'h8, 3'b000, 2, 0, got_w);
        join
        chk("same_edge_old", got_w, 32'h00000001);
        do_read(32'h8, 3'b000, 0, 0, got);
        chk("same_edge_new", got, 32'hA5A5A5A5);
        do_write(32'h41, 3'b000, 32'h0, 4'hF, 0, 0, 1'b0);

        // Reset during a long write delay.
        cfg_write_delay = 5'd20;
        awaddr = 32'hC; awprot = 3'b000; wdata = 32'h87654321; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        repeat (5) @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        chk("mid_awready", awready, 1'b0);
        chk("mid_wready", wready, 1'b0);
        chk("mid_bvalid", bvalid, 1'b0);
        chk("mid_bresp", bresp, 2'b00);
        chk("mid_rdata", rdata, 32'h0);
        chk("mid_rresp", rresp, 2'b00);
        awvalid = 1'b0; wvalid = 1'b0;
        clear_model();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        seen_b = 1'b0;
        repeat (25) begin
            @(posedge aclk); #1;
            if (bvalid) seen_b = 1'b1;
        end
        chk("no_resp_after_rst", seen_b, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            do_read(BASE + 32'(i * 4), 3'b000, 0, 0, got);
        chk("rst_word3", got_w === 32'h1 ? model_mem[3] : 32'hX, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
